// File: rtl/cdc_pkg.sv
// Shared types and constants for the CDC request arbiter and its round-robin picker.
package cdc_pkg;

  typedef enum logic [0:0] {
    ST_IDLE = 1'b0,
    ST_BUSY = 1'b1
  } arb_state_t;

  localparam arb_state_t  STATE_RST = ST_IDLE;
  localparam int unsigned PTR_RST   = 32'd0;

  // Tag width for n requesters; never narrower than one bit.
  function automatic int id_width(input int n);
    return (n < 2) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/cdc_rr_pick.sv
// Combinational round-robin picker: first requester at or after ptr, searching with wrap.
module cdc_rr_pick
  import cdc_pkg::*;
#(
  parameter int N  = 4,
  parameter int IW = id_width(N)
) (
  input  logic [N-1:0]  req,
  input  logic [IW-1:0] ptr,
  output logic [N-1:0]  gnt,
  output logic [IW-1:0] idx,
  output logic          any
);

  localparam logic [IW:0] N_EXT = (IW+1)'(N);

  logic [N-1:0] rot_s;
  logic [IW:0]  off_s;
  logic [IW:0]  sum_s;

  // Rotate ptr down to bit 0, take the lowest set bit, then map the offset back with one wrap
  always_comb begin
    rot_s = N'({req, req} >> ptr);
    off_s = '0;
    for (int k = N - 1; k >= 0; k--) begin
      off_s = rot_s[k] ? (IW+1)'(k) : off_s;
    end
    any   = |rot_s;
    sum_s = {1'b0, ptr} + off_s;
    idx   = (sum_s >= N_EXT) ? IW'(sum_s - N_EXT) : sum_s[IW-1:0];
    gnt   = any ? (N'(1) << idx) : '0;
  end

endmodule

// File: rtl/cdc_req_arbiter.sv
// Round-robin arbiter sharing one CDC handshake channel among NUM_REQ source-domain requesters.
module cdc_req_arbiter
  import cdc_pkg::*;
#(
  parameter  int NUM_REQ = 4,
  parameter  int DATA_W  = 64,
  localparam int ID_W    = id_width(NUM_REQ)
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic [NUM_REQ-1:0]        req_in,
  output logic [NUM_REQ-1:0]        rdy_in,
  input  logic [NUM_REQ*DATA_W-1:0] data_in,
  output logic                      req_out,
  input  logic                      rdy_out,
  output logic [DATA_W-1:0]         data_out,
  output logic [ID_W-1:0]           id_out
);

  localparam logic [ID_W-1:0] PTR_LAST = ID_W'(NUM_REQ - 1);
  localparam logic [ID_W-1:0] PTR_INIT = ID_W'(PTR_RST);

  arb_state_t          state_r;
  arb_state_t          state_nxt_s;
  logic [ID_W-1:0]     ptr_r;
  logic [ID_W-1:0]     ptr_nxt_s;
  logic [ID_W-1:0]     g_idx_s;
  logic [NUM_REQ-1:0]  gnt_s;
  logic                any_s;
  logic                free_s;
  logic                accept_s;
  logic [DATA_W-1:0]   sel_data_s;
  logic [DATA_W-1:0]   data_r;
  logic [ID_W-1:0]     id_r;

  cdc_rr_pick #(
    .N  (NUM_REQ),
    .IW (ID_W)
  ) u_pick (
    .req (req_in),
    .ptr (ptr_r),
    .gnt (gnt_s),
    .idx (g_idx_s),
    .any (any_s)
  );

  // Slot is free when empty or when the held beat leaves this cycle; nothing is offered in reset
  always_comb begin
    free_s     = (state_r == ST_IDLE) | rdy_out;
    accept_s   = any_s & free_s & rst_n;
    rdy_in     = accept_s ? gnt_s : '0;
    ptr_nxt_s  = accept_s ? ((g_idx_s == PTR_LAST) ? '0 : g_idx_s + ID_W'(1)) : ptr_r;
    sel_data_s = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      sel_data_s = sel_data_s | (gnt_s[i] ? data_in[i*DATA_W +: DATA_W] : '0);
    end
  end

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r <= STATE_RST;
    end else begin
      state_r <= state_nxt_s;
    end
  end

  // Next state: an accept fills the slot, a drain without accept empties it
  always_comb begin
    state_nxt_s = state_r;
    case (state_r)
      ST_IDLE: state_nxt_s = accept_s ? ST_BUSY : ST_IDLE;
      ST_BUSY: state_nxt_s = (accept_s | ~rdy_out) ? ST_BUSY : ST_IDLE;
      default: state_nxt_s = STATE_RST;
    endcase
  end

  // Output decode straight from flops, so rdy_out never reaches the channel side combinationally
  always_comb begin
    req_out  = (state_r == ST_BUSY);
    data_out = data_r;
    id_out   = id_r;
  end

  // Pointer and held beat change only on accept; a drain leaves data/id as they were
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ptr_r  <= PTR_INIT;
      data_r <= '0;
      id_r   <= '0;
    end else begin
      ptr_r <= ptr_nxt_s;
      if (accept_s) begin
        data_r <= sel_data_s;
        id_r   <= g_idx_s;
      end
    end
  end

endmodule

// File: tb/tb_cdc_req_arbiter.sv
// Self-checking bench for cdc_req_arbiter: a 4-requester instance with a reference scoreboard
// and a 3-requester instance for the non-power-of-two pointer wrap.
module tb_cdc_req_arbiter;

  localparam int NR = 4;
  localparam int DW = 16;

  typedef struct packed {
    logic [1:0]    id;
    logic [DW-1:0] data;
  } beat_t;

  logic            clk   = 1'b0;
  logic            rst_n = 1'b1;

  logic [NR-1:0]    req4  = '0;
  logic [NR*DW-1:0] data4 = '0;
  logic             rdy4  = 1'b0;
  logic [NR-1:0]    a_rdy_in;
  logic             a_req_out;
  logic [DW-1:0]    a_data_out;
  logic [1:0]       a_id_out;

  logic [2:0]       req3  = '0;
  logic [3*DW-1:0]  data3 = '0;
  logic             rdy3  = 1'b0;
  logic [2:0]       b_rdy_in;
  logic             b_req_out;
  logic [DW-1:0]    b_data_out;
  logic [1:0]       b_id_out;

  int tests_run    = 0;
  int tests_failed = 0;

  always #5 clk = ~clk;

  cdc_req_arbiter #(.NUM_REQ(NR), .DATA_W(DW)) dut_a (
    .clk      (clk),
    .rst_n    (rst_n),
    .req_in   (req4),
    .rdy_in   (a_rdy_in),
    .data_in  (data4),
    .req_out  (a_req_out),
    .rdy_out  (rdy4),
    .data_out (a_data_out),
    .id_out   (a_id_out)
  );

  cdc_req_arbiter #(.NUM_REQ(3), .DATA_W(DW)) dut_b (
    .clk      (clk),
    .rst_n    (rst_n),
    .req_in   (req3),
    .rdy_in   (b_rdy_in),
    .data_in  (data3),
    .req_out  (b_req_out),
    .rdy_out  (rdy3),
    .data_out (b_data_out),
    .id_out   (b_id_out)
  );

  // Reference model of dut_a: linear wrap-around search plus a scoreboard of held beats
  logic          m_busy;
  int            m_ptr;
  logic [NR-1:0] m_acc;
  logic [NR-1:0] exp_rdy;
  int            exp_g;
  int            scan_i;
  logic          found;
  beat_t         sb[$];

  always_comb begin
    exp_rdy = '0;
    exp_g   = 0;
    found   = 1'b0;
    scan_i  = 0;
    for (int k = 0; k < NR; k++) begin
      scan_i = (m_ptr + k) % NR;
      if (!found && req4[scan_i]) begin
        found = 1'b1;
        exp_g = scan_i;
      end
    end
    if (found && rst_n && (!m_busy || rdy4)) exp_rdy[exp_g] = 1'b1;
  end

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_busy <= 1'b0;
      m_ptr  <= 0;
      m_acc  <= '0;
      sb.delete();
    end else begin
      m_acc <= exp_rdy;
      if (m_busy && rdy4) sb.delete(0);
      if (exp_rdy != '0) begin
        sb.push_back({exp_g[1:0], data4[exp_g*DW +: DW]});
        m_ptr <= (exp_g + 1) % NR;
      end
      m_busy <= (exp_rdy != '0) || (m_busy && !rdy4);
    end
  end

  task automatic test_reset();
    #1 rst_n = 1'b0;
    req4 = '0; rdy4 = 1'b0; req3 = '0; rdy3 = 1'b0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    for (int c = 0; c < 10; c++) begin
      @(negedge clk); #1;
      tests_run++;
      if ({a_req_out, a_data_out, a_id_out, a_rdy_in, b_req_out, b_data_out, b_id_out, b_rdy_in} !== '0) begin
        tests_failed++;
        $display("FAIL reset_state cycle %0d: req_out=%b data_out=%h id_out=%0d rdy_in=%b (b: %b %h %0d %b), required all zero",
                 c, a_req_out, a_data_out, a_id_out, a_rdy_in, b_req_out, b_data_out, b_id_out, b_rdy_in);
      end
    end
  endtask

  task automatic test_round_robin();
    int exp_id;
    @(negedge clk);
    for (int i = 0; i < NR; i++) data4[i*DW +: DW] = 16'hA000 + 16'(i);
    req4 = 4'b1111;
    rdy4 = 1'b1;
    for (int k = 1; k <= 6; k++) begin
      @(negedge clk); #1;
      exp_id = (k - 1) % NR;
      tests_run++;
      if (a_req_out !== 1'b1 || a_id_out !== 2'(exp_id) || a_data_out !== 16'hA000 + 16'(exp_id)) begin
        tests_failed++;
        $display("FAIL rr_grant beat %0d: req_out=%b id=%0d data=%h, required 1 id=%0d data=%h",
                 k, a_req_out, a_id_out, a_data_out, exp_id, 16'hA000 + 16'(exp_id));
      end
      tests_run++;
      if (sb.size() != 1 || {a_id_out, a_data_out} !== sb[0]) begin
        tests_failed++;
        $display("FAIL rr_scoreboard beat %0d: got id=%0d data=%h, scoreboard entries=%0d", k, a_id_out, a_data_out, sb.size());
      end
    end
    req4 = '0;
    @(negedge clk); #1;
    tests_run++;
    if (a_req_out !== 1'b0) begin
      tests_failed++;
      $display("FAIL rr_drain: req_out=%b, required 0", a_req_out);
    end
  endtask

  task automatic test_hold();
    @(negedge clk);
    data4[2*DW +: DW] = 16'hABCD;
    req4 = 4'b0100;
    rdy4 = 1'b0;
    @(negedge clk);
    data4[3*DW +: DW] = 16'h3333;
    req4 = 4'b1000;
    for (int c = 0; c < 5; c++) begin
      if (c == 2) req4 = 4'b1001;
      #1;
      tests_run++;
      if (a_req_out !== 1'b1 || a_data_out !== 16'hABCD || a_id_out !== 2'd2 || a_rdy_in !== 4'b0000) begin
        tests_failed++;
        $display("FAIL hold cycle %0d: req_out=%b data=%h id=%0d rdy_in=%b, required 1 abcd 2 0000",
                 c, a_req_out, a_data_out, a_id_out, a_rdy_in);
      end
      @(negedge clk);
    end
    rdy4 = 1'b1;
    #1;
    tests_run++;
    if (a_rdy_in !== 4'b1000) begin
      tests_failed++;
      $display("FAIL hold_release_rdy: rdy_in=%b, required 1000", a_rdy_in);
    end
    @(negedge clk);
    req4 = 4'b0001;
    #1;
    tests_run++;
    if (a_req_out !== 1'b1 || a_id_out !== 2'd3 || a_data_out !== 16'h3333) begin
      tests_failed++;
      $display("FAIL hold_next_beat: req_out=%b id=%0d data=%h, required 1 3 3333", a_req_out, a_id_out, a_data_out);
    end
    @(negedge clk);
    req4 = '0;
    #1;
    tests_run++;
    if (a_req_out !== 1'b1 || a_id_out !== 2'd0 || a_data_out !== 16'hA000) begin
      tests_failed++;
      $display("FAIL hold_wrap_beat: req_out=%b id=%0d data=%h, required 1 0 a000", a_req_out, a_id_out, a_data_out);
    end
    @(negedge clk);
  endtask

  task automatic test_wrap3();
    @(negedge clk);
    data3[2*DW +: DW] = 16'h2222;
    req3 = 3'b100;
    rdy3 = 1'b1;
    #1;
    tests_run++;
    if (b_rdy_in !== 3'b100) begin
      tests_failed++;
      $display("FAIL wrap3_first_rdy: rdy_in=%b, required 100", b_rdy_in);
    end
    @(negedge clk);
    data3[0*DW +: DW] = 16'h0F0F;
    data3[2*DW +: DW] = 16'h2B2B;
    req3 = 3'b101;
    #1;
    tests_run++;
    if (b_req_out !== 1'b1 || b_id_out !== 2'd2 || b_data_out !== 16'h2222 || b_rdy_in !== 3'b001) begin
      tests_failed++;
      $display("FAIL wrap3_ptr_wrap: req_out=%b id=%0d data=%h rdy_in=%b, required 1 2 2222 001",
               b_req_out, b_id_out, b_data_out, b_rdy_in);
    end
    @(negedge clk);
    req3 = 3'b100;
    #1;
    tests_run++;
    if (b_id_out !== 2'd0 || b_data_out !== 16'h0F0F || b_rdy_in !== 3'b100) begin
      tests_failed++;
      $display("FAIL wrap3_req0_wins: id=%0d data=%h rdy_in=%b, required 0 0f0f 100", b_id_out, b_data_out, b_rdy_in);
    end
    @(negedge clk);
    req3 = '0;
    #1;
    tests_run++;
    if (b_id_out !== 2'd2 || b_data_out !== 16'h2B2B) begin
      tests_failed++;
      $display("FAIL wrap3_req2_again: id=%0d data=%h, required 2 2b2b", b_id_out, b_data_out);
    end
    @(negedge clk); #1;
    tests_run++;
    if (b_req_out !== 1'b0) begin
      tests_failed++;
      $display("FAIL wrap3_drain: req_out=%b, required 0", b_req_out);
    end
    rdy3 = 1'b0;
  endtask

  task automatic test_async_reset();
    @(negedge clk);
    data4[1*DW +: DW] = 16'h1111;
    req4 = 4'b0010;
    rdy4 = 1'b0;
    @(negedge clk);
    req4 = 4'b1000;
    data4[3*DW +: DW] = 16'h3C3C;
    #1;
    tests_run++;
    if (a_req_out !== 1'b1 || a_id_out !== 2'd1 || a_data_out !== 16'h1111) begin
      tests_failed++;
      $display("FAIL areset_busy: req_out=%b id=%0d data=%h, required 1 1 1111", a_req_out, a_id_out, a_data_out);
    end
    #1 rst_n = 1'b0;
    #1;
    tests_run++;
    if (a_req_out !== 1'b0 || a_data_out !== '0 || a_id_out !== 2'd0 || a_rdy_in !== 4'b0000) begin
      tests_failed++;
      $display("FAIL areset_clear: req_out=%b data=%h id=%0d rdy_in=%b, required all zero",
               a_req_out, a_data_out, a_id_out, a_rdy_in);
    end
    @(negedge clk);
    rst_n = 1'b1;
    rdy4  = 1'b1;
    @(negedge clk);
    req4 = '0;
    #1;
    tests_run++;
    if (a_req_out !== 1'b1 || a_id_out !== 2'd3 || a_data_out !== 16'h3C3C) begin
      tests_failed++;
      $display("FAIL areset_restart: req_out=%b id=%0d data=%h, required 1 3 3c3c", a_req_out, a_id_out, a_data_out);
    end
    @(negedge clk);
  endtask

  task automatic test_random();
    logic [NR-1:0] pend;
    int            waitcnt[NR];
    pend = '0;
    for (int i = 0; i < NR; i++) waitcnt[i] = 0;
    for (int c = 0; c < 3000; c++) begin
      @(negedge clk);
      tests_run++;
      if (a_req_out !== m_busy || (sb.size() != 0 && {a_id_out, a_data_out} !== sb[0])) begin
        tests_failed++;
        $display("FAIL rand_beat cycle %0d: req_out=%b id=%0d data=%h, required req_out=%b entries=%0d",
                 c, a_req_out, a_id_out, a_data_out, m_busy, sb.size());
      end
      for (int i = 0; i < NR; i++) begin
        if (m_acc[i]) begin
          tests_run++;
          if (!pend[i] || waitcnt[i] > NR - 1) begin
            tests_failed++;
            $display("FAIL rand_fairness req %0d: waited %0d grants (pending=%b), required at most %0d",
                     i, waitcnt[i], pend[i], NR - 1);
          end
          pend[i]    = 1'b0;
          waitcnt[i] = 0;
        end else if (pend[i] && m_acc != '0) begin
          waitcnt[i]++;
        end
      end
      for (int i = 0; i < NR; i++) begin
        if (!pend[i] && $urandom_range(0, 2) == 0) begin
          pend[i] = 1'b1;
          data4[i*DW +: DW] = 16'($urandom);
        end
      end
      req4 = pend;
      rdy4 = ($urandom_range(0, 3) != 0);
      #1;
      tests_run++;
      if (!$onehot0(a_rdy_in) || a_rdy_in !== exp_rdy) begin
        tests_failed++;
        $display("FAIL rand_rdy_in cycle %0d: rdy_in=%b, required %b", c, a_rdy_in, exp_rdy);
      end
    end
    req4 = '0;
    rdy4 = 1'b1;
    repeat (2) @(negedge clk);
    #1;
    tests_run++;
    if (a_req_out !== 1'b0 || sb.size() != 0) begin
      tests_failed++;
      $display("FAIL rand_final_drain: req_out=%b entries=%0d, required 0 0", a_req_out, sb.size());
    end
  endtask

  initial begin
    test_reset();
    test_round_robin();
    test_hold();
    test_wrap3();
    test_async_reset();
    test_random();
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
